// File: rtl/ecc_wr_arbiter_if.sv
// Requester-side write handshake bundle for ecc_wr_arbiter: two valid/ready
// write ports (req0 = FIFO path, req1 = scrubber/DMA path).
interface ecc_wr_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [STRB_WIDTH-1:0] req0_strobe;
   logic [DATA_WIDTH-1:0] req0_data;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [STRB_WIDTH-1:0] req1_strobe;
   logic [DATA_WIDTH-1:0] req1_data;

   modport master (
      output req0_valid, req0_addr, req0_strobe, req0_data,
      output req1_valid, req1_addr, req1_strobe, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_addr, req0_strobe, req0_data,
      input  req1_valid, req1_addr, req1_strobe, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/ecc_wr_arbiter.sv
// Round-robin arbiter sharing one registered ECC encoder write path between two
// requesters. Define ECC_ARB_MEM_INIT_EN to add the post-reset zero-fill sequencer.
module ecc_wr_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 16
) (
   input  logic                       ecc_arb_clk,
   input  logic                       ecc_arb_rst,
   input  logic [DATA_WIDTH-1:0]      cfg_ecc_en,
   ecc_wr_arbiter_if.slave            req,
   input  logic                       init_start,
   output logic                       wr_en_o,
   output logic [ADDR_WIDTH-1:0]      wr_addr_o,
   output logic [DATA_WIDTH/8-1:0]    wr_strobe_o,
   output logic [DATA_WIDTH-1:0]      wr_data_o,
   output logic [DATA_WIDTH-1:0]      ECC_en_o,
   output logic                       grant_id_o,
   output logic                       init_busy,
   output logic                       init_done
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  last_grant_q;
   logic                  gnt0, gnt1, hs;
   logic                  in_init;
   logic [ADDR_WIDTH-1:0] init_addr;

`ifdef ECC_ARB_MEM_INIT_EN
   localparam int CNT_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic {ARB, INIT} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             init_last;

   always_ff @(posedge ecc_arb_clk) begin
      if (ecc_arb_rst) begin
         state_q   <= ARB;
         cnt_q     <= '0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         init_done <= init_last;
      end
   end

   // init_start is only honoured from ARB, so a pulse during a fill never restarts it
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      init_last = 1'b0;
      case (state_q)
         ARB: if (init_start) state_d = INIT;
         INIT: begin
            if (cnt_q == CNT_W'(MEM_DEPTH - 1)) begin
               init_last = 1'b1;
               state_d   = ARB;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ARB;
      endcase
   end

   assign in_init   = (state_q == INIT);
   assign init_busy = in_init;
   assign init_addr = ADDR_WIDTH'(cnt_q);
`else
   logic unused_init_start;
   assign unused_init_start = init_start;
   assign in_init   = 1'b0;
   assign init_busy = 1'b0;
   assign init_done = 1'b0;
   assign init_addr = '0;
`endif

   // On a tie the requester that did not win last time gets the slot
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!ecc_arb_rst && !in_init) begin
         if (req.req0_valid && req.req1_valid) begin
            gnt0 = last_grant_q;
            gnt1 = !last_grant_q;
         end else begin
            gnt0 = req.req0_valid;
            gnt1 = req.req1_valid;
         end
      end
   end

   assign hs             = gnt0 | gnt1;
   assign req.req0_ready = gnt0;
   assign req.req1_ready = gnt1;

   // Idle cycles drop wr_en_o but leave the payload registers untouched
   always_ff @(posedge ecc_arb_clk) begin
      if (ecc_arb_rst) begin
         last_grant_q <= 1'b1;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_strobe_o  <= '0;
         wr_data_o    <= '0;
         ECC_en_o     <= '0;
         grant_id_o   <= 1'b0;
      end else if (in_init) begin
         wr_en_o      <= 1'b1;
         wr_addr_o    <= init_addr;
         wr_strobe_o  <= {STRB_WIDTH{1'b1}};
         wr_data_o    <= '0;
         ECC_en_o     <= cfg_ecc_en;
         grant_id_o   <= 1'b0;
      end else if (hs) begin
         last_grant_q <= gnt1;
         wr_en_o      <= 1'b1;
         wr_addr_o    <= gnt1 ? req.req1_addr   : req.req0_addr;
         wr_strobe_o  <= gnt1 ? req.req1_strobe : req.req0_strobe;
         wr_data_o    <= gnt1 ? req.req1_data   : req.req0_data;
         ECC_en_o     <= cfg_ecc_en;
         grant_id_o   <= gnt1;
      end else begin
         wr_en_o      <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ecc_wr_arbiter.sv
// Directed + randomized bench for ecc_wr_arbiter, checked against a
// rule-level model (tie-break bit plus a queue of pending fill addresses).
module tb_ecc_wr_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = DW / 8;
   localparam int MD = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] cfg = '0;
   logic          init_start = 1'b0;
   logic          wr_en, gid, busy, done;
   logic [AW-1:0] wr_addr;
   logic [SW-1:0] wr_strb;
   logic [DW-1:0] wr_data, ecc_o;

   ecc_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req ();

   ecc_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(MD)) dut (
      .ecc_arb_clk (clk),
      .ecc_arb_rst (rst),
      .cfg_ecc_en  (cfg),
      .req         (req),
      .init_start  (init_start),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_strobe_o (wr_strb),
      .wr_data_o   (wr_data),
      .ECC_en_o    (ecc_o),
      .grant_id_o  (gid),
      .init_busy   (busy),
      .init_done   (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic          m_last;
   int            m_initq[$];
   logic          e_wr, e_gid, e_busy, e_done;
   logic [AW-1:0] e_addr;
   logic [SW-1:0] e_strb;
   logic [DW-1:0] e_data, e_ecc;

   // pending random request fields, held while a request waits
   logic          pend0 = 1'b0, pend1 = 1'b0;
   logic [AW-1:0] p_a0, p_a1;
   logic [SW-1:0] p_s0, p_s1;
   logic [DW-1:0] p_d0, p_d1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("wr_en",   64'(wr_en),   64'(e_wr));
      chk("wr_addr", 64'(wr_addr), 64'(e_addr));
      chk("wr_strb", 64'(wr_strb), 64'(e_strb));
      chk("wr_data", 64'(wr_data), 64'(e_data));
      chk("ecc_en",  64'(ecc_o),   64'(e_ecc));
      chk("grant",   64'(gid),     64'(e_gid));
      chk("busy",    64'(busy),    64'(e_busy));
      chk("done",    64'(done),    64'(e_done));
   endtask

   // Called at a negedge; holds reset across one rising edge with both requesters valid.
   task automatic apply_reset();
      rst = 1'b1;
      init_start = 1'b0;
      req.req0_valid = 1'b1;
      req.req1_valid = 1'b1;
      #1;
      chk("rst_ready0", 64'(req.req0_ready), 64'd0);
      chk("rst_ready1", 64'(req.req1_ready), 64'd0);
      @(negedge clk);
      m_last = 1'b1;
      m_initq.delete();
      e_wr = 0; e_gid = 0; e_busy = 0; e_done = 0;
      e_addr = '0; e_strb = '0; e_data = '0; e_ecc = '0;
      check_outputs();
      rst = 1'b0;
      req.req0_valid = 1'b0;
      req.req1_valid = 1'b0;
      pend0 = 1'b0;
      pend1 = 1'b0;
   endtask

   task automatic step(input logic v0, input logic v1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] ecc, input logic ist,
                       output logic h0, output logic h1);
      logic was_busy;
      req.req0_valid = v0; req.req0_addr = a0; req.req0_strobe = s0; req.req0_data = d0;
      req.req1_valid = v1; req.req1_addr = a1; req.req1_strobe = s1; req.req1_data = d1;
      cfg = ecc;
      init_start = ist;
      #1;
      was_busy = (m_initq.size() != 0);
      h0 = !was_busy && v0 && (!v1 || m_last);
      h1 = !was_busy && v1 && (!v0 || !m_last);
      chk("ready0", 64'(req.req0_ready), 64'(h0));
      chk("ready1", 64'(req.req1_ready), 64'(h1));
      e_done = 1'b0;
      if (was_busy) begin
         e_wr = 1'b1; e_addr = AW'(m_initq.pop_front()); e_strb = '1; e_data = '0;
         e_ecc = ecc; e_gid = 1'b0;
         e_done = (m_initq.size() == 0);
      end else if (h0 || h1) begin
         e_wr = 1'b1; e_addr = h1 ? a1 : a0; e_strb = h1 ? s1 : s0; e_data = h1 ? d1 : d0;
         e_ecc = ecc; e_gid = h1; m_last = h1;
      end else begin
         e_wr = 1'b0;
      end
`ifdef ECC_ARB_MEM_INIT_EN
      if (!was_busy && ist)
         for (int i = 0; i < MD; i++) m_initq.push_back(i);
`endif
      e_busy = (m_initq.size() != 0);
      @(negedge clk);
      check_outputs();
      init_start = 1'b0;
   endtask

   task automatic rstep(input logic v0, input logic v1, input logic ist);
      logic h0, h1;
      if (!pend0) begin p_a0 = $urandom; p_s0 = SW'($urandom); p_d0 = $urandom; end
      if (!pend1) begin p_a1 = $urandom; p_s1 = SW'($urandom); p_d1 = $urandom; end
      step(v0, v1, p_a0, p_a1, p_s0, p_s1, p_d0, p_d1, $urandom, ist, h0, h1);
      pend0 = v0 && !h0;
      pend1 = v1 && !h1;
   endtask

   initial begin
      logic       h0, h1;
      logic [5:0] seq;
      int         ndone;

      req.req0_valid = 0; req.req0_addr = '0; req.req0_strobe = '0; req.req0_data = '0;
      req.req1_valid = 0; req.req1_addr = '0; req.req1_strobe = '0; req.req1_data = '0;
      @(negedge clk);
      apply_reset();

      // single req0 write, then an idle cycle that must hold the payload
      step(1, 0, 32'h10, 32'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 0, h0, h1);
      chk("first_ready", 64'(h0), 64'd1);
      chk("first_addr", 64'(wr_addr), 64'h10);
      chk("first_data", 64'(wr_data), 64'hDEADBEEF);
      step(0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 0, h0, h1);

      // cfg_ecc_en change between two req0 writes
      step(1, 0, 32'h20, 32'h0, 4'h3, 4'h0, 32'h11111111, 32'h0, 32'hFFFFFFFF, 0, h0, h1);
      chk("ecc_first", 64'(ecc_o), 64'hFFFFFFFF);
      step(1, 0, 32'h24, 32'h0, 4'hC, 4'h0, 32'h22222222, 32'h0, 32'h0, 0, h0, h1);
      chk("ecc_second", 64'(ecc_o), 64'h0);

      // both valid from reset: strict alternation starting with req0
      apply_reset();
      for (int i = 0; i < 6; i++) begin rstep(1, 1, 0); seq[i] = gid; end
      chk("alt_order", 64'(seq), 64'(6'b101010));

      // req1 alone three times, then req0 joins
      apply_reset();
      for (int i = 0; i < 3; i++) begin rstep(0, 1, 0); seq[i] = gid; end
      for (int i = 3; i < 6; i++) begin rstep(1, 1, 0); seq[i] = gid; end
      chk("join_order", 64'(seq), 64'(6'b010111));

`ifdef ECC_ARB_MEM_INIT_EN
      // full zero-fill with both requesters pressing
      apply_reset();
      ndone = 0;
      rstep(1, 1, 1);
      for (int i = 0; i < MD + 4; i++) begin
         rstep(1, 1, (i == 3));
         if (done) ndone++;
      end
      chk("init_done_count", 64'(ndone), 64'd1);

      // reset partway through a fill, then restart from address 0
      rstep(0, 0, 1);
      for (int i = 0; i < 6; i++) rstep(0, 0, 0);
      apply_reset();
      rstep(1, 0, 1);
      for (int i = 0; i < MD + 3; i++) rstep(1, 0, 0);
`endif

      // randomized traffic
      apply_reset();
      for (int i = 0; i < 400; i++)
         rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
